// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status types, controller numbers and decoder state encoding
package midi_pkg;
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON = 4'h9;
  localparam logic [3:0] ST_POLY_AT = 4'hA;
  localparam logic [3:0] ST_CC = 4'hB;
  localparam logic [3:0] ST_PROG = 4'hC;
  localparam logic [3:0] ST_CH_AT = 4'hD;
  localparam logic [3:0] ST_BEND = 4'hE;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [6:0] CC_RESET_ALL = 7'd121;
  localparam logic [13:0] PITCH_CENTRE = 14'd8192;
  typedef enum logic [1:0] {S_IDLE, S_D1, S_D2} state_t;
endpackage

// File: rtl/midi_note_pitch_dec.sv
// midi_note_pitch_dec: monophonic last-note-priority MIDI channel-voice decoder
//   CLK/RESET: clock, synchronous active-high reset
//   BYTE_IN/BYTE_VALID: received byte and its one-cycle strobe
//   NOTE/VELOCITY/GATE/NOTE_EVT: current note, its velocity, held flag, change strobe
//   PITCH: 14-bit pitch bend, 8192 = centre
module midi_note_pitch_dec
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic [6:0]  NOTE,
  output logic [13:0] PITCH,
  output logic [6:0]  VELOCITY,
  output logic        GATE,
  output logic        NOTE_EVT
);
  state_t st, st_nx;
  logic [3:0] rs_type, rs_ch;
  logic [6:0] d1, m1;
  logic sys, status, data, one_byte, done, mine;
  logic note_on, note_off, bend, all_off, rst_ctl;
  // Realtime bytes (F8-FF) match none of the classes below, so they fall through untouched.
  always_comb begin
    sys = BYTE_IN[7:3] == 5'b11110;
    status = BYTE_IN[7] && BYTE_IN[7:4] != 4'hF;
    data = !BYTE_IN[7];
    one_byte = rs_type == ST_PROG || rs_type == ST_CH_AT;
    st_nx = st;
    if (BYTE_VALID)
      st_nx = sys ? S_IDLE :
              status ? S_D1 :
              !data ? st :
              st == S_D1 ? (one_byte ? S_D1 : S_D2) :
              st == S_D2 ? S_D1 : st;
    done = BYTE_VALID && data && ((st == S_D1 && one_byte) || st == S_D2);
    // For one-byte messages the completing byte is data1 itself.
    m1 = st == S_D2 ? d1 : BYTE_IN[6:0];
    mine = done && rs_ch == CHANNEL;
    note_on = mine && rs_type == ST_NOTE_ON && BYTE_IN[6:0] != 7'd0;
    note_off = mine && (rs_type == ST_NOTE_OFF || (rs_type == ST_NOTE_ON && BYTE_IN[6:0] == 7'd0))
               && m1 == NOTE && GATE;
    bend = mine && rs_type == ST_BEND;
    all_off = mine && rs_type == ST_CC && m1 == CC_ALL_NOTES_OFF;
    rst_ctl = mine && rs_type == ST_CC && m1 == CC_RESET_ALL;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st <= S_IDLE;
      rs_type <= 4'd0;
      rs_ch <= 4'd0;
      d1 <= 7'd0;
      NOTE <= 7'd0;
      PITCH <= PITCH_CENTRE;
      VELOCITY <= 7'd0;
      GATE <= 1'b0;
      NOTE_EVT <= 1'b0;
    end else begin
      st <= st_nx;
      if (BYTE_VALID && status) {rs_type, rs_ch} <= BYTE_IN;
      if (BYTE_VALID && data && st == S_D1) d1 <= BYTE_IN[6:0];
      NOTE_EVT <= note_on || note_off || (all_off && GATE);
      if (note_on) begin
        NOTE <= BYTE_IN[6:0] == 7'd0 ? NOTE : m1;
        VELOCITY <= BYTE_IN[6:0];
        GATE <= 1'b1;
      end
      if (note_off || all_off) GATE <= 1'b0;
      if (bend) PITCH <= {BYTE_IN[6:0], m1};
      if (rst_ctl) PITCH <= PITCH_CENTRE;
    end
  end
endmodule

// File: tb/tb_midi_note_pitch_dec.sv
// tb_midi_note_pitch_dec: directed vector table plus randomized check against a message-level model
module tb_midi_note_pitch_dec;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic [7:0] BYTE_IN = 8'd0;
  logic BYTE_VALID = 1'b0;
  logic [6:0] NOTE, VELOCITY;
  logic [13:0] PITCH;
  logic GATE, NOTE_EVT;
  int n_chk = 0;
  int n_fail = 0;

  midi_note_pitch_dec #(.CHANNEL(4'd0)) dut (
    .CLK(clk), .RESET(RESET), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .NOTE(NOTE), .PITCH(PITCH), .VELOCITY(VELOCITY), .GATE(GATE), .NOTE_EVT(NOTE_EVT)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r;
    bit v;
    logic [7:0] b;
    int note;
    int pitch;
    int vel;
    bit gate;
    bit evt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input logic [7:0] b, input int n, input int p,
                     input int vl, input bit g, input bit e);
    vec_t x;
    x.r = r; x.v = v; x.b = b; x.note = n; x.pitch = p; x.vel = vl; x.gate = g; x.evt = e;
    tbl.push_back(x);
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] b);
    @(negedge clk);
    RESET = r;
    BYTE_VALID = v;
    BYTE_IN = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int n, input int p, input int vl, input bit g, input bit e);
    logic [6:0] en, ev;
    logic [13:0] ep;
    en = n[6:0]; ep = p[13:0]; ev = vl[6:0];
    n_chk++;
    if ({NOTE, PITCH, VELOCITY, GATE, NOTE_EVT} !== {en, ep, ev, g, e}) begin
      n_fail++;
      $display("FAIL %s: got note=%0d pitch=%0d vel=%0d gate=%0b evt=%0b, want note=%0d pitch=%0d vel=%0d gate=%0b evt=%0b",
               nm, NOTE, PITCH, VELOCITY, GATE, NOTE_EVT, en, ep, ev, g, e);
    end
  endtask

  // Message-level reference: running status byte plus a queue of collected data bytes.
  int rs;
  int bq[$];
  int mn, mp, mv;
  bit mg, me;

  task automatic model_reset();
    rs = -1; bq.delete(); mn = 0; mp = 8192; mv = 0; mg = 0; me = 0;
  endtask

  task automatic model_byte(input int b);
    int need, typ, a, c;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin rs = -1; bq.delete(); return; end
    if (b >= 'h80) begin rs = b; bq.delete(); return; end
    if (rs < 0) return;
    typ = rs / 16;
    need = (typ == 12 || typ == 13) ? 1 : 2;
    bq.push_back(b);
    if (bq.size() < need) return;
    a = bq[0];
    c = need == 2 ? bq[1] : 0;
    bq.delete();
    if (rs % 16 != 0) return;
    if (typ == 9 && c != 0) begin
      mn = a; mv = c; mg = 1; me = 1;
    end else if (typ == 8 || typ == 9) begin
      if (a == mn && mg) begin mg = 0; me = 1; end
    end else if (typ == 14) mp = c * 128 + a;
    else if (typ == 11 && a == 123) begin
      if (mg) me = 1;
      mg = 0;
    end else if (typ == 11 && a == 121) mp = 8192;
  endtask

  initial begin
    add(1, 0, 8'h00, 0, 8192, 0, 0, 0);
    add(0, 1, 8'h90, 0, 8192, 0, 0, 0);
    add(0, 1, 8'h3C, 0, 8192, 0, 0, 0);
    add(0, 0, 8'h64, 0, 8192, 0, 0, 0);
    add(0, 1, 8'h64, 60, 8192, 100, 1, 1);
    add(0, 1, 8'h40, 60, 8192, 100, 1, 0);
    add(0, 1, 8'h50, 64, 8192, 80, 1, 1);
    add(0, 1, 8'h40, 64, 8192, 80, 1, 0);
    add(0, 1, 8'h00, 64, 8192, 80, 0, 1);
    add(0, 1, 8'h90, 64, 8192, 80, 0, 0);
    add(0, 1, 8'h3C, 64, 8192, 80, 0, 0);
    add(0, 1, 8'h64, 60, 8192, 100, 1, 1);
    add(0, 1, 8'h90, 60, 8192, 100, 1, 0);
    add(0, 1, 8'h40, 60, 8192, 100, 1, 0);
    add(0, 1, 8'h64, 64, 8192, 100, 1, 1);
    add(0, 1, 8'h80, 64, 8192, 100, 1, 0);
    add(0, 1, 8'h3C, 64, 8192, 100, 1, 0);
    add(0, 1, 8'h00, 64, 8192, 100, 1, 0);
    add(0, 1, 8'h80, 64, 8192, 100, 1, 0);
    add(0, 1, 8'h40, 64, 8192, 100, 1, 0);
    add(0, 1, 8'h00, 64, 8192, 100, 0, 1);
    add(0, 1, 8'hE0, 64, 8192, 100, 0, 0);
    add(0, 1, 8'h00, 64, 8192, 100, 0, 0);
    add(0, 1, 8'hF8, 64, 8192, 100, 0, 0);
    add(0, 1, 8'h60, 64, 12288, 100, 0, 0);
    add(0, 1, 8'hB0, 64, 12288, 100, 0, 0);
    add(0, 1, 8'h79, 64, 12288, 100, 0, 0);
    add(0, 1, 8'h00, 64, 8192, 100, 0, 0);
    add(0, 1, 8'hE0, 64, 8192, 100, 0, 0);
    add(0, 1, 8'h7F, 64, 8192, 100, 0, 0);
    add(0, 1, 8'h90, 64, 8192, 100, 0, 0);
    add(0, 1, 8'h30, 64, 8192, 100, 0, 0);
    add(0, 1, 8'h7F, 48, 8192, 127, 1, 1);
    add(0, 1, 8'h91, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h30, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h7F, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h90, 48, 8192, 127, 1, 0);
    add(0, 1, 8'hF0, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h3C, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h64, 48, 8192, 127, 1, 0);
    add(0, 1, 8'hF7, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h3C, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h64, 48, 8192, 127, 1, 0);
    add(0, 1, 8'hB0, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h7B, 48, 8192, 127, 1, 0);
    add(0, 1, 8'h00, 48, 8192, 127, 0, 1);
    add(0, 1, 8'hE0, 48, 8192, 127, 0, 0);
    add(0, 1, 8'h00, 48, 8192, 127, 0, 0);
    add(0, 1, 8'h60, 48, 12288, 127, 0, 0);
    add(0, 1, 8'hE0, 48, 12288, 127, 0, 0);
    add(0, 1, 8'h10, 48, 12288, 127, 0, 0);
    add(1, 0, 8'h00, 0, 8192, 0, 0, 0);
    add(0, 1, 8'h20, 0, 8192, 0, 0, 0);
    add(0, 1, 8'h40, 0, 8192, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].b);
      check($sformatf("vec%0d", i), tbl[i].note, tbl[i].pitch, tbl[i].vel, tbl[i].gate, tbl[i].evt);
    end
    drive(1, 0, 8'h00);
    model_reset();
    check("rand_reset", mn, mp, mv, mg, me);
    for (int i = 0; i < 3000; i++) begin
      int k, sel, b;
      bit r, v;
      k = $urandom_range(0, 99);
      r = k < 2;
      v = k >= 15;
      sel = $urandom_range(0, 19);
      if (sel == 0) b = $urandom_range('hF8, 'hFF);
      else if (sel == 1) b = $urandom_range(0, 1) ? 'hF0 : 'hF7;
      else if (sel < 7) begin
        int types[8] = '{8, 9, 9, 10, 11, 12, 13, 14};
        b = types[$urandom_range(0, 7)] * 16 + ($urandom_range(0, 2) == 2 ? 1 : 0);
      end else begin
        int vals[7] = '{60, 61, 62, 0, 121, 123, 0};
        int j;
        j = $urandom_range(0, 6);
        b = j == 6 ? $urandom_range(0, 127) : vals[j];
      end
      drive(r, v, b[7:0]);
      me = 0;
      if (r) model_reset();
      else if (v) model_byte(b);
      check($sformatf("rand%0d", i), mn, mp, mv, mg, me);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/midi_note_pitch_dec.md
Name: midi_note_pitch_dec

Overview:
Monophonic MIDI channel-voice decoder.
- Consumes the byte stream from the MIDI UART receiver.
- Produces the NOTE / PITCH pair consumed by the note-pitch-to-DDS converter, plus GATE and VELOCITY for the envelope.
- Handles running status, realtime interleaving, SysEx skipping and channel filtering.
- Last-note priority: the most recent Note On wins.

Parameters:
CHANNEL, 4'd0, MIDI channel (0-15) this decoder responds to.

Ports:
CLK  input  1  system clock.
RESET  input  1  synchronous, active-high reset.
BYTE_IN  input  8  received MIDI byte, valid only when BYTE_VALID=1.
BYTE_VALID  input  1  one-cycle strobe per received byte; minimum spacing 1 cycle.
NOTE  output  7  current note number, registered.
PITCH  output  14  pitch-bend value; 8192 = centre, registered.
VELOCITY  output  7  velocity of the current note, registered.
GATE  output  1  1 while a note is held.
NOTE_EVT  output  1  one-cycle strobe when NOTE/GATE/VELOCITY change from a message.

Behaviour:
- Reset values (synchronous on RESET=1):
  - NOTE=0, PITCH=14'd8192, VELOCITY=0, GATE=0, NOTE_EVT=0.
  - Running status cleared; state=S_IDLE.
  - Applies mid-message too: partial data is discarded.
- Byte classes:
  - F8-FF realtime: ignored completely; no state or data change, even mid-message.
  - F0-F7 system common/SysEx: clear running status, go to S_IDLE. After F0, all data bytes are ignored until the next status byte.
  - 80-EF channel status: latch type (bits 7:4) and channel (bits 3:0) into running status, go to S_D1. Any partial message is abandoned.
  - 00-7F data: handled per state.
- States:
  - S_IDLE: data byte with no valid running status is ignored.
  - S_D1: latch data1 (7 bits).
    - Types Cx/Dx (one data byte): message complete, stay in S_D1 for running status.
    - All other types: go to S_D2.
  - S_D2: latch data2, message complete, return to S_D1 (running status retained).
- On message completion, if channel == CHANNEL:
  - 9x with data2 != 0: NOTE<=data1, VELOCITY<=data2, GATE<=1, NOTE_EVT pulses.
  - 8x, or 9x with data2 == 0: only if data1 == NOTE and GATE == 1, then GATE<=0 and NOTE_EVT pulses. NOTE and VELOCITY hold (release tail keeps pitch). Note Off for any other note: no effect.
  - Ex: PITCH <= {data2, data1}. Both bytes are applied atomically at completion; PITCH never shows a half-updated value.
  - Bx with data1=123 (All Notes Off): GATE<=0, NOTE_EVT pulses if GATE was 1.
  - Bx with data1=121 (Reset All Controllers): PITCH<=8192.
  - Ax, Cx, Dx, other Bx: consumed, no output change.
- Other channel: bytes are consumed with the same state sequencing; outputs unchanged.
- Latency: outputs update on the CLK edge after the cycle in which the completing byte has BYTE_VALID=1. NOTE_EVT is high for exactly that one cycle.
- BYTE_VALID=0: no state change.
- Running status always restarts at data1 after a completed message.

Decomposition:
- Shared package midi_pkg:
  - Status type constants: ST_NOTE_OFF=4'h8, ST_NOTE_ON=4'h9, ST_POLY_AT=4'hA, ST_CC=4'hB, ST_PROG=4'hC, ST_CH_AT=4'hD, ST_BEND=4'hE.
  - CC_ALL_NOTES_OFF=7'd123, CC_RESET_ALL=7'd121, PITCH_CENTRE=14'd8192.
  - State encoding S_IDLE / S_D1 / S_D2.
- Single module; no sub-module. The byte classifier is combinational inside the module.

Test Plan:
- Reset, then bytes 90 3C 64: NOTE=60, VELOCITY=100, GATE=1, one NOTE_EVT pulse; PITCH stays 8192.
- Running status: 90 3C 64 then 40 50 (no status byte): NOTE=64, VELOCITY=80, GATE=1; then 40 00: GATE=0, NOTE stays 64.
- Note Off mismatch: 90 3C 64, 90 40 64, 80 3C 00: GATE stays 1, NOTE=64; then 80 40 00: GATE=0.
- Pitch bend with realtime interleave: E0 00 F8 60: PITCH=12288, and only after the 60 byte; then B0 79 00: PITCH=8192.
- Abandon/channel checks:
  - E0 7F 90 30 7F: PITCH unchanged, NOTE=48.
  - CHANNEL=0, then 91 30 7F: no output change.
  - F0 3C 64 F7 then 3C 64: no change (running status cleared).
- Reset mid-message: E0 10, assert RESET one cycle, then 20: PITCH=8192, GATE=0, byte 20 ignored.
